// File: rtl/pipeline_credit_pkg.sv
// Shared sizing helpers and error-bit indices for the pipeline credit wrapper.
package pipeline_credit_pkg;

  localparam int ERR_UNEXPECTED = 0;
  localparam int ERR_OVERFLOW   = 1;

  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int ptr_width(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipeline_credit_fifo.sv
// Result FIFO: captures every pipeline output and presents the head as registered data.
module pipeline_credit_fifo
  import pipeline_credit_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic                       empty_o,
  output logic [WIDTH-1:0]           head_o,
  output logic [cnt_width(DEPTH)-1:0] count_o,
  output logic                       overflow_o
);

  localparam int CW = cnt_width(DEPTH);
  localparam int PW = ptr_width(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    rdPtr_q, rdPtr_d;
  logic [PW-1:0]    wrPtr_q, wrPtr_d;
  logic [CW-1:0]    count_q, count_d;
  logic             full, doPush, doPop;

  function automatic logic [PW-1:0] nextPtr(input logic [PW-1:0] ptr);
    return (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
  endfunction

  assign full       = (count_q == CW'(DEPTH));
  assign empty_o    = (count_q == '0);
  assign doPop      = pop_i & ~empty_o;
  // A pop frees the slot in the same cycle, so a full FIFO may still accept a push alongside it.
  assign doPush     = push_i & (~full | doPop);
  assign overflow_o = push_i & ~doPush;
  assign head_o     = mem_q[rdPtr_q];
  assign count_o    = count_q;

  always_comb begin
    rdPtr_d = doPop ? nextPtr(rdPtr_q) : rdPtr_q;
    wrPtr_d = doPush ? nextPtr(wrPtr_q) : wrPtr_q;
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdPtr_q <= '0;
      wrPtr_q <= '0;
      count_q <= '0;
    end else begin
      rdPtr_q <= rdPtr_d;
      wrPtr_q <= wrPtr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && doPush) begin
      mem_q[wrPtr_q] <= data_i;
    end
  end

endmodule

// File: rtl/pipeline_credit_wrapper.sv
// Credit-based ready/valid wrapper around a fixed-latency, non-stallable pipeline.
module pipeline_credit_wrapper
  import pipeline_credit_pkg::*;
#(
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = 32,
  parameter int DEPTH     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 up_valid,
  output logic                 up_ready,
  input  logic [IN_WIDTH-1:0]  up_data,
  output logic                 pipe_input_valid,
  output logic [IN_WIDTH-1:0]  pipe_x,
  input  logic                 pipe_output_valid,
  input  logic [OUT_WIDTH-1:0] pipe_out,
  output logic                 dn_valid,
  input  logic                 dn_ready,
  output logic [OUT_WIDTH-1:0] dn_data,
  output logic [1:0]           err
);

  localparam int CW = cnt_width(DEPTH);

  logic [CW-1:0] inflight_q, inflight_d;
  logic [1:0]    err_q, err_d;
  logic [CW-1:0] fifoCount;
  logic [CW:0]   occupancy;
  logic          upFire, retire, popFire, fifoEmpty, overflow;

  // Every issued item owns a FIFO slot until popped, so the pipeline can never outrun the buffer.
  assign occupancy = {1'b0, inflight_q} + {1'b0, fifoCount};
  assign up_ready  = rst_n & (occupancy < (CW + 1)'(DEPTH));

  assign upFire           = up_valid & up_ready;
  assign pipe_input_valid = upFire;
  assign pipe_x           = up_data;
  assign retire           = pipe_output_valid & (inflight_q != '0);
  assign popFire          = dn_valid & dn_ready;
  assign dn_valid         = ~fifoEmpty;
  assign err              = err_q;

  pipeline_credit_fifo #(
    .WIDTH (OUT_WIDTH),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (pipe_output_valid),
    .pop_i      (popFire),
    .data_i     (pipe_out),
    .empty_o    (fifoEmpty),
    .head_o     (dn_data),
    .count_o    (fifoCount),
    .overflow_o (overflow)
  );

  always_comb begin
    inflight_d = inflight_q;
    err_d      = err_q;
    case ({upFire, retire})
      2'b10:   inflight_d = inflight_q + CW'(1);
      2'b01:   inflight_d = inflight_q - CW'(1);
      default: inflight_d = inflight_q;
    endcase
    if (pipe_output_valid && (inflight_q == '0)) begin
      err_d[ERR_UNEXPECTED] = 1'b1;
    end
    if (overflow) begin
      err_d[ERR_OVERFLOW] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inflight_q <= '0;
      err_q      <= '0;
    end else begin
      inflight_q <= inflight_d;
      err_q      <= err_d;
    end
  end

endmodule
